// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: slave end of the MEM-stage req/ack access
// interface, with programmable wait states, byte-lane stores and a range check.
module dm_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [31:0]           r_mem [DEPTH];

  logic                  r_wr;
  logic                  r_in_range;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;

  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_eff_wr;
  logic                  w_eff_in_range;
  logic [ADDR_WIDTH-1:0] w_eff_idx;
  logic [31:0]           w_eff_wdata;
  logic [3:0]            w_eff_be;
  logic [31:0]           w_old_word;
  logic [31:0]           w_merged;
  logic                  w_unused_addr;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  assign w_offset      = i_addr - BASE_ADDR;
  assign w_in_range    = (w_offset[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
  assign w_unused_addr = ^w_offset[1:0];

  // With zero wait states RESP is entered on the acceptance edge, so the
  // live request fields are used instead of the not-yet-latched copies.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_eff_wr       = i_wr;
      w_eff_in_range = w_in_range;
      w_eff_idx      = w_offset[ADDR_WIDTH+1:2];
      w_eff_wdata    = i_wdata;
      w_eff_be       = i_be;
    end else begin
      w_eff_wr       = r_wr;
      w_eff_in_range = r_in_range;
      w_eff_idx      = r_idx;
      w_eff_wdata    = r_wdata;
      w_eff_be       = r_be;
    end
  end

  assign w_old_word = r_mem[w_eff_idx];
  assign w_merged   = merge_lanes(w_old_word, w_eff_wdata, w_eff_be);
  assign o_busy     = (r_state != S_IDLE) | i_req;

  // Next-state and wait-counter logic.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LP_CNT_INIT;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, counter and frozen request fields.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wr       <= 1'b0;
      r_in_range <= 1'b0;
      r_idx      <= {ADDR_WIDTH{1'b0}};
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_wr       <= i_wr;
        r_in_range <= w_in_range;
        r_idx      <= w_offset[ADDR_WIDTH+1:2];
        r_wdata    <= i_wdata;
        r_be       <= i_be;
      end
    end
  end

  // Memory array; store commits on the edge entering RESP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_enter_resp && w_eff_wr && w_eff_in_range) begin
      r_mem[w_eff_idx] <= w_merged;
    end
  end

  // Registered response: RData holds until the next Ack.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rdata <= 32'd0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_ack <= w_enter_resp;
      o_err <= w_enter_resp & ~w_eff_in_range;
      if (w_enter_resp) begin
        if (!w_eff_in_range) begin
          o_rdata <= 32'd0;
        end else if (w_eff_wr) begin
          o_rdata <= w_merged;
        end else begin
          o_rdata <= w_old_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a vector table on a 2-wait-state instance,
// plus hand sequences for Req toggling, mid-access reset and zero wait states.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_z, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata_a, rdata_z;
  logic        ack_a, busy_a, err_a, ack_z, busy_z, err_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_req(req_a), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_rdata(rdata_a), .o_ack(ack_a),
    .o_busy(busy_a), .o_err(err_a));

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_z (
    .i_clk(clk), .i_reset(reset), .i_req(req_z), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_rdata(rdata_z), .o_ack(ack_z),
    .o_busy(busy_z), .o_err(err_z));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sel_ack(input int sel);
    return (sel == 0) ? ack_a : ack_z;
  endfunction
  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy_a : busy_z;
  endfunction
  function automatic logic sel_err(input int sel);
    return (sel == 0) ? err_a : err_z;
  endfunction
  function automatic logic [31:0] sel_rdata(input int sel);
    return (sel == 0) ? rdata_a : rdata_z;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
  task automatic txn(input int sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err, input string name);
    int lat;
    wr = w; addr = a; wdata = d; be = b;
    if (sel == 0) req_a = 1'b1; else req_z = 1'b1;
    #1;
    check({name, "/busy_c0"}, 32'(sel_busy(sel)), 32'd1);
    @(posedge clk); #1;
    req_a = 1'b0; req_z = 1'b0;
    addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD; be = 4'b1111;
    lat = 1;
    while (sel_ack(sel) !== 1'b1 && lat < 20) begin
      check({name, "/busy_wait"}, 32'(sel_busy(sel)), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/rdata"}, sel_rdata(sel), exp_rd);
    check({name, "/err"}, 32'(sel_err(sel)), 32'(exp_err));
    check({name, "/busy_resp"}, 32'(sel_busy(sel)), 32'd1);
    @(posedge clk); #1;
    check({name, "/ack_off"}, 32'(sel_ack(sel)), 32'd0);
    check({name, "/busy_off"}, 32'(sel_busy(sel)), 32'd0);
    check({name, "/rdata_hold"}, sel_rdata(sel), exp_rd);
  endtask

  initial begin
    int acks;
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_1234, 4'b0011, 32'hDEAD_1234, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_1234, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_1234, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_1234, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'b1111, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0013, 32'hA500_0000, 4'b1000, 32'hA5AD_1234, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};

    reset = 1'b1; req_a = 1'b0; req_z = 1'b0; wr = 1'b0;
    addr = 32'd0; wdata = 32'd0; be = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/ack_a", 32'(ack_a), 32'd0);
    check("reset/busy_a", 32'(busy_a), 32'd0);
    check("reset/err_a", 32'(err_a), 32'd0);
    check("reset/rdata_a", rdata_a, 32'd0);
    check("reset/ack_z", 32'(ack_z), 32'd0);
    check("reset/rdata_z", rdata_z, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 3,
          vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Req toggled during WAIT and RESP, Addr changed after acceptance.
    wr = 1'b0; addr = 32'h0000_0010; be = 4'b0000; req_a = 1'b1;
    @(posedge clk); #1;
    addr = 32'h0000_0000;
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      req_a = (c == 1 || c == 3) ? 1'b1 : 1'b0;
      if (ack_a === 1'b1) begin
        acks++;
        check("toggle/ack_cycle", 32'(c), 32'd3);
        check("toggle/rdata", rdata_a, 32'hA5AD_1234);
      end
      @(posedge clk); #1;
    end
    check("toggle/ack_count", 32'(acks), 32'd1);
    check("toggle/busy_idle", 32'(busy_a), 32'd0);

    // Reset during WAIT of a store to 0x20.
    wr = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D; be = 4'b1111; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_wait/ack", 32'(ack_a), 32'd0);
    check("rst_wait/busy", 32'(busy_a), 32'd0);
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      if (ack_a === 1'b1) acks++;
      @(posedge clk); #1;
    end
    check("rst_wait/no_ack", 32'(acks), 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 3, 32'h0000_0000, 1'b0, "rst_load20");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 3, 32'h0000_0000, 1'b0, "rst_load10");

    // Zero wait-state instance.
    txn(1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'b1111, 1, 32'h1122_3344, 1'b0, "z_store");
    txn(1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 1, 32'h1122_3344, 1'b0, "z_load");
    txn(1, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, 1, 32'h11BB_33DD, 1'b0, "z_merge");
    txn(1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 1, 32'h11BB_33DD, 1'b0, "z_load2");
    txn(1, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 1, 32'h0000_0000, 1'b1, "z_oor");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the pipeline's data-memory access interface.
- Accepts load/store requests from the MEM stage over a req/ack handshake, with byte-lane enables.
- Inserts a programmable number of wait states and asserts Busy so the hazard unit can stall F/D/E/M while an access is outstanding.
- Replaces the single-cycle dm for the multi-cycle memory configuration.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words (1024 words = 4 KB).
- WAIT_CYCLES, 2, wait states between request acceptance and Ack; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- Clk  in  1  clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  request valid; sampled only in IDLE
- Wr  in  1  1 = store, 0 = load
- Addr  in  32  byte address (ALUOutM); Addr[1:0] ignored
- WData  in  32  store data, already lane-aligned
- BE  in  4  byte enables; BE[i] covers WData[8i+7:8i]
- RData  out  32  load data; valid while Ack=1 and held until the next Ack
- Ack  out  1  one-cycle completion pulse
- Busy  out  1  1 while a transaction is outstanding; drives the MEM-stage stall
- Err  out  1  pulses with Ack when the address is out of range

Behaviour:
- Reset (synchronous) forces all of the following on the next edge:
  - state=IDLE; RData=0, Ack=0, Err=0, Busy=0
  - every memory word cleared to 0
  - any in-flight transaction aborted and its write discarded
  - Reset has priority over Req in the same cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, Req=1: latch Wr/Addr/WData/BE, compute range check.
    - WAIT_CYCLES>0: go to WAIT, load cnt=WAIT_CYCLES-1.
    - WAIT_CYCLES=0: go straight to RESP.
  - IDLE, Req=0: stay.
  - WAIT: cnt==0 -> RESP; otherwise cnt decrements. Req is ignored.
  - RESP: unconditionally -> IDLE. Req is ignored in this cycle.
- Latency:
  - Ack is high in exactly one cycle, WAIT_CYCLES+1 cycles after the acceptance edge.
  - Minimum request spacing is WAIT_CYCLES+2 cycles.
- Busy:
  - Combinational: (state!=IDLE) | (state==IDLE & Req).
  - This stalls the pipeline in the same cycle the request first appears.
  - Busy is 0 in the cycle after RESP unless a new Req is present.
- Offset and range:
  - offset = Addr - BASE_ADDR, 32-bit unsigned.
  - In range iff offset < 4*2^ADDR_WIDTH; word index = offset[ADDR_WIDTH+1:2].
- Store:
  - Committed on the edge entering RESP.
  - Per lane: mem[idx][8i+7:8i] <= WData[8i+7:8i] when BE[i]=1; lanes with BE[i]=0 are unchanged.
  - BE=4'b0000 still completes with Ack and changes nothing.
  - RData after a store = the merged word.
- Load:
  - RData <= mem[idx] on the edge entering RESP.
  - Full word is returned; BE is ignored and lane extraction/sign extension is done by the MEM stage.
- Out of range:
  - No write occurs; RData <= 0; Err=1 together with Ack.
  - FSM timing is identical to an in-range access.
- Latched request fields are frozen from acceptance until RESP, so changes on Addr/WData/BE during WAIT have no effect.
- Read-after-write: a load accepted after a store's Ack returns the stored data, with no bypass needed.

Test Plan:
- Reset, then WAIT_CYCLES=2, load Addr=0x0 -> Ack in 3rd cycle after acceptance; RData=0x00000000, Err=0; Busy high for cycles 0..3.
- Store Addr=0x10, WData=0xDEADBEEF, BE=1111, then load 0x10 -> RData=0xDEADBEEF.
- Store Addr=0x10, WData=0x00001234, BE=0011 onto 0xDEADBEEF -> subsequent load returns 0xDEAD1234; store with BE=0000 -> word unchanged.
- Load Addr=0x1000 (out of range for 1024 words) -> Ack with Err=1, RData=0; a store to 0x1000 leaves all words unchanged.
- Toggle Req during WAIT and RESP -> ignored, exactly one Ack per accepted request; with WAIT_CYCLES=0, Ack comes 1 cycle after acceptance.
- Reset asserted during WAIT of a store to 0x20 -> no Ack, Busy=0 next cycle, load of 0x20 afterwards returns 0.
